// File: rtl/vc_tx_arbiter.sv
// VC TX arbiter: stages the head TLP of each per-VC TX FIFO, checks it against
// link-partner flow-control credits and round-robins eligible VCs onto a
// single registered valid/ready output toward the data-link layer.
module vc_tx_arbiter #(
    parameter int unsigned DATA_WIDTH = 224,
    parameter int unsigned HDR_CW     = 8,
    parameter int unsigned DATA_CW    = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vc0_empty,
    output logic                  vc0_rd_en,
    input  logic [DATA_WIDTH-1:0] vc0_rd_data,
    input  logic                  vc1_empty,
    output logic                  vc1_rd_en,
    input  logic [DATA_WIDTH-1:0] vc1_rd_data,
    input  logic [HDR_CW-1:0]     vc0_hdr_limit,
    input  logic [DATA_CW-1:0]    vc0_data_limit,
    input  logic [HDR_CW-1:0]     vc1_hdr_limit,
    input  logic [DATA_CW-1:0]    vc1_data_limit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_vc
);

    // Half the modular credit space: differences up to this count as "enough".
    localparam logic [HDR_CW-1:0]  HdrHalf  = HDR_CW'(1) << (HDR_CW - 1);
    localparam logic [DATA_CW-1:0] DataHalf = DATA_CW'(1) << (DATA_CW - 1);

    logic [1:0]            empty;
    logic [DATA_WIDTH-1:0] rd_data    [2];
    logic [HDR_CW-1:0]     hdr_limit  [2];
    logic [DATA_CW-1:0]    data_limit [2];

    logic [1:0]            stage_valid_q, stage_valid_d;
    logic [HDR_CW-1:0]     hdr_cons_q  [2];
    logic [HDR_CW-1:0]     hdr_cons_d  [2];
    logic [DATA_CW-1:0]    data_cons_q [2];
    logic [DATA_CW-1:0]    data_cons_d [2];
    logic                  last_grant_q, last_grant_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_vc_q, out_vc_d;

    logic [DATA_CW-1:0]    req       [2];
    logic [HDR_CW-1:0]     hdr_room  [2];
    logic [DATA_CW-1:0]    data_room [2];
    logic [1:0]            eligible;
    logic [1:0]            grant;
    logic [1:0]            rd_en;
    logic                  free;

    // Data credits needed by an entry: ceil(length_dw / 4), length 0 meaning 1024.
    function automatic logic [DATA_CW-1:0] data_req(input logic [DATA_WIDTH-1:0] entry);
        logic [10:0] len;
        logic [10:0] rounded;
        len = (entry[DATA_WIDTH-2 -: 10] == 10'd0) ? 11'd1024 : {1'b0, entry[DATA_WIDTH-2 -: 10]};
        rounded = (len + 11'd3) >> 2;
        return entry[DATA_WIDTH-1] ? DATA_CW'(rounded) : '0;
    endfunction

    // Gather per-VC inputs into arrays so the rest of the logic can loop over VCs.
    always_comb begin
        empty         = {vc1_empty, vc0_empty};
        rd_data[0]    = vc0_rd_data;
        rd_data[1]    = vc1_rd_data;
        hdr_limit[0]  = vc0_hdr_limit;
        hdr_limit[1]  = vc1_hdr_limit;
        data_limit[0] = vc0_data_limit;
        data_limit[1] = vc1_data_limit;
    end

    // Credit check of each staged TLP using modular distance to the limit.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < 2; i++) begin
            req[i]       = data_req(rd_data[i]);
            hdr_room[i]  = hdr_limit[i] - (hdr_cons_q[i] + HDR_CW'(1));
            data_room[i] = data_limit[i] - (data_cons_q[i] + req[i]);
            eligible[i]  = stage_valid_q[i] && (hdr_room[i] <= HdrHalf)
                           && (data_room[i] <= DataHalf);
        end
    end

    // Round-robin grant, only when the output register can take a new TLP.
    always_comb begin
        free  = !out_valid_q || out_ready;
        grant = 2'b00;
        if (free) begin
            if (eligible == 2'b11) begin
                grant = last_grant_q ? 2'b01 : 2'b10;
            end else begin
                grant = eligible;
            end
        end
        // Pop to fill an empty stage or to refill the one being granted.
        for (int i = 0; i < 2; i++) begin
            rd_en[i] = rst_n && !empty[i] && (!stage_valid_q[i] || grant[i]);
        end
    end

    // Next-state for stages, credit counters, arbitration pointer and output register.
    always_comb begin
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_vc_d     = out_vc_q;
        for (int i = 0; i < 2; i++) begin
            stage_valid_d[i] = rd_en[i] ? 1'b1 : (grant[i] ? 1'b0 : stage_valid_q[i]);
            hdr_cons_d[i]    = grant[i] ? hdr_cons_q[i] + HDR_CW'(1) : hdr_cons_q[i];
            data_cons_d[i]   = grant[i] ? data_cons_q[i] + req[i] : data_cons_q[i];
        end
        if (grant != 2'b00) begin
            last_grant_d = grant[1];
            out_valid_d  = 1'b1;
            out_data_d   = rd_data[grant[1]];
            out_vc_d     = grant[1];
        end else if (free) begin
            out_valid_d  = 1'b0;
        end
    end

    // State registers; last_grant resets to VC1 so VC0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_q <= '0;
            for (int i = 0; i < 2; i++) begin
                hdr_cons_q[i]  <= '0;
                data_cons_q[i] <= '0;
            end
            last_grant_q  <= 1'b1;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_vc_q      <= 1'b0;
        end else begin
            stage_valid_q <= stage_valid_d;
            for (int i = 0; i < 2; i++) begin
                hdr_cons_q[i]  <= hdr_cons_d[i];
                data_cons_q[i] <= data_cons_d[i];
            end
            last_grant_q  <= last_grant_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_vc_q      <= out_vc_d;
        end
    end

    assign vc0_rd_en = rd_en[0];
    assign vc1_rd_en = rd_en[1];
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_vc    = out_vc_q;

endmodule

// File: tb/tb_vc_tx_arbiter.sv
// Directed bench for vc_tx_arbiter with simple behavioural FIFO models per VC.
module tb_vc_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vc0_empty, vc1_empty;
    logic         vc0_rd_en, vc1_rd_en;
    logic [223:0] vc0_rd_data, vc1_rd_data;
    logic [7:0]   vc0_hdr_limit, vc1_hdr_limit;
    logic [11:0]  vc0_data_limit, vc1_data_limit;
    logic         out_valid, out_ready, out_vc;
    logic [223:0] out_data;

    int checks = 0;
    int errors = 0;

    // FIFO models: pushed by the stimulus block, popped on rd_en with data next cycle.
    logic [223:0] mem0 [512];
    logic [223:0] mem1 [512];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;

    assign vc0_empty = (wr0 == rd0);
    assign vc1_empty = (wr1 == rd1);

    always #5 clk = ~clk;

    // FIFO pop side.
    always @(posedge clk) begin
        if (vc0_rd_en) begin
            vc0_rd_data <= mem0[rd0];
            rd0 <= rd0 + 1;
        end
        if (vc1_rd_en) begin
            vc1_rd_data <= mem1[rd1];
            rd1 <= rd1 + 1;
        end
    end

    vc_tx_arbiter #(
        .DATA_WIDTH(224),
        .HDR_CW    (8),
        .DATA_CW   (12)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vc0_empty     (vc0_empty),
        .vc0_rd_en     (vc0_rd_en),
        .vc0_rd_data   (vc0_rd_data),
        .vc1_empty     (vc1_empty),
        .vc1_rd_en     (vc1_rd_en),
        .vc1_rd_data   (vc1_rd_data),
        .vc0_hdr_limit (vc0_hdr_limit),
        .vc0_data_limit(vc0_data_limit),
        .vc1_hdr_limit (vc1_hdr_limit),
        .vc1_data_limit(vc1_data_limit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_vc        (out_vc)
    );

    function automatic logic [223:0] mk(input logic hd, input logic [9:0] len,
                                        input logic [15:0] tag);
        logic [223:0] e;
        e = '0;
        e[223] = hd;
        e[222:213] = len;
        e[15:0] = tag;
        return e;
    endfunction

    task automatic push0(input logic [223:0] e);
        mem0[wr0] = e;
        wr0 = wr0 + 1;
    endtask

    task automatic push1(input logic [223:0] e);
        mem1[wr1] = e;
        wr1 = wr1 + 1;
    endtask

    task automatic check(input string tag, input logic [223:0] got, input logic [223:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic vc, input logic [223:0] data);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".vc"}, out_vc, vc);
        check({tag, ".data"}, out_data, data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [223:0] e0 [4];
        logic [223:0] e1 [4];
        logic [223:0] x, y0, y1, p0, p1, p2, t1, t2, t3, r0, r1, r2;
        int seen;

        // Reset state.
        rst_n = 1'b0;
        out_ready = 1'b1;
        vc0_hdr_limit = 8'd8;
        vc0_data_limit = 12'd0;
        vc1_hdr_limit = 8'd50;
        vc1_data_limit = 12'd100;
        #1;
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_data", out_data, '0);
        check("rst.out_vc", out_vc, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: single no-data TLP on VC0, output two cycles after empty falls.
        @(negedge clk);
        x = mk(1'b0, 10'd1, 16'h0011);
        push0(x);
        #1;
        check("t1.rd_en0", vc0_rd_en, 1'b1);
        check("t1.rd_en1", vc1_rd_en, 1'b0);
        @(negedge clk);
        check("t1.c1_valid", out_valid, 1'b0);
        @(negedge clk);
        check_out("t1.out", 1'b0, x);
        check("t1.hdr_cons0", dut.hdr_cons_q[0], 8'd1);
        check("t1.data_cons0", dut.data_cons_q[0], 12'd0);
        @(negedge clk);
        check("t1.idle", out_valid, 1'b0);

        // 2: four TLPs on each VC; VC0 was granted last, so VC1 takes the first tie.
        vc0_hdr_limit = 8'd50;
        vc0_data_limit = 12'd100;
        for (int i = 0; i < 4; i++) begin
            e0[i] = mk(1'b1, 10'd4, 16'h0020 + 16'(i));
            e1[i] = mk(1'b1, 10'd4, 16'h0040 + 16'(i));
            push0(e0[i]);
            push1(e1[i]);
        end
        #1;
        check("t2.rd_en0", vc0_rd_en, 1'b1);
        check("t2.rd_en1", vc1_rd_en, 1'b1);
        @(negedge clk);
        check("t2.c1_valid", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_out($sformatf("t2.vc1_%0d", i), 1'b1, e1[i]);
            @(negedge clk);
            check_out($sformatf("t2.vc0_%0d", i), 1'b0, e0[i]);
        end
        @(negedge clk);
        check("t2.idle", out_valid, 1'b0);
        check("t2.hdr_cons0", dut.hdr_cons_q[0], 8'd5);
        check("t2.data_cons0", dut.data_cons_q[0], 12'd4);
        check("t2.hdr_cons1", dut.hdr_cons_q[1], 8'd4);
        check("t2.data_cons1", dut.data_cons_q[1], 12'd4);

        // 3: VC0 length-5 TLP needs 2 data credits; data_cons0=4, limit 5 blocks it.
        vc0_data_limit = 12'd5;
        x  = mk(1'b1, 10'd5, 16'h0030);
        y0 = mk(1'b0, 10'd1, 16'h0050);
        y1 = mk(1'b0, 10'd1, 16'h0051);
        push0(x);
        push1(y0);
        push1(y1);
        @(negedge clk);
        @(negedge clk);
        check_out("t3.y0", 1'b1, y0);
        @(negedge clk);
        check_out("t3.y1", 1'b1, y1);
        @(negedge clk);
        check("t3.blocked", out_valid, 1'b0);
        check("t3.blocked_cons", dut.data_cons_q[0], 12'd4);
        vc0_data_limit = 12'd6;
        @(negedge clk);
        check_out("t3.x", 1'b0, x);
        check("t3.data_cons0", dut.data_cons_q[0], 12'd6);
        check("t3.hdr_cons0", dut.hdr_cons_q[0], 8'd6);
        @(negedge clk);
        check("t3.idle", out_valid, 1'b0);

        // 4: output stall holds everything stable for five cycles.
        out_ready = 1'b0;
        p0 = mk(1'b0, 10'd2, 16'h0060);
        p1 = mk(1'b0, 10'd2, 16'h0061);
        p2 = mk(1'b0, 10'd2, 16'h0062);
        push0(p0);
        push0(p1);
        @(negedge clk);
        check("t4.c1_valid", out_valid, 1'b0);
        @(negedge clk);
        push0(p2);
        #1;
        check_out("t4.hold0", 1'b0, p0);
        check("t4.rd_en0_0", vc0_rd_en, 1'b0);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check_out($sformatf("t4.hold%0d", i), 1'b0, p0);
            check($sformatf("t4.rd_en0_%0d", i), vc0_rd_en, 1'b0);
        end
        check("t4.hdr_cons0", dut.hdr_cons_q[0], 8'd7);
        out_ready = 1'b1;
        @(negedge clk);
        check_out("t4.p1", 1'b0, p1);
        @(negedge clk);
        check_out("t4.p2", 1'b0, p2);
        @(negedge clk);
        check("t4.idle", out_valid, 1'b0);
        check("t4.hdr_cons0_end", dut.hdr_cons_q[0], 8'd9);

        // 5: stream VC1 hdr_cons from 6 up to 255, then wrap against limit 0.
        for (int i = 0; i < 249; i++) begin
            push1(mk(1'b0, 10'd1, 16'h1000 + 16'(i)));
        end
        seen = 0;
        vc1_hdr_limit = 8'd70;
        for (int i = 0; i < 400 && seen < 249; i++) begin
            @(negedge clk);
            if (out_valid && out_vc) seen++;
            vc1_hdr_limit = 8'(70 + seen);
        end
        check("t5.streamed", seen, 249);
        check("t5.hdr_cons1_255", dut.hdr_cons_q[1], 8'd255);
        vc1_hdr_limit = 8'd0;
        t1 = mk(1'b0, 10'd1, 16'h0071);
        t2 = mk(1'b0, 10'd1, 16'h0072);
        push1(t1);
        push1(t2);
        @(negedge clk);
        check("t5.c1_valid", out_valid, 1'b0);
        @(negedge clk);
        check_out("t5.t1", 1'b1, t1);
        check("t5.hdr_cons1_wrap", dut.hdr_cons_q[1], 8'd0);
        @(negedge clk);
        check("t5.blocked0", out_valid, 1'b0);
        @(negedge clk);
        check("t5.blocked1", out_valid, 1'b0);
        check("t5.rd_en1", vc1_rd_en, 1'b0);

        // 6: reset mid-stream with both stages valid and the output stalled.
        out_ready = 1'b0;
        r0 = mk(1'b0, 10'd1, 16'h0080);
        r1 = mk(1'b0, 10'd1, 16'h0081);
        r2 = mk(1'b0, 10'd1, 16'h0082);
        t3 = mk(1'b0, 10'd1, 16'h0073);
        push0(r0);
        push0(r1);
        push0(r2);
        push1(t3);
        @(negedge clk);
        @(negedge clk);
        check_out("t6.pre", 1'b0, r0);
        check("t6.stages", dut.stage_valid_q, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.rst_valid", out_valid, 1'b0);
        check("t6.rst_data", out_data, '0);
        check("t6.rst_vc", out_vc, 1'b0);
        check("t6.rst_rd_en0", vc0_rd_en, 1'b0);
        check("t6.rst_rd_en1", vc1_rd_en, 1'b0);
        check("t6.rst_stages", dut.stage_valid_q, 2'b00);
        check("t6.rst_hdr_cons0", dut.hdr_cons_q[0], 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        vc1_hdr_limit = 8'd50;
        #1;
        check("t6.rd_en0", vc0_rd_en, 1'b1);
        check("t6.rd_en1", vc1_rd_en, 1'b1);
        @(negedge clk);
        check("t6.c1_valid", out_valid, 1'b0);
        @(negedge clk);
        check_out("t6.tie_vc0", 1'b0, r2);
        @(negedge clk);
        check_out("t6.then_vc1", 1'b1, t3);
        @(negedge clk);
        check("t6.idle", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vc_tx_arbiter.md
Name: vc_tx_arbiter

Overview:
- Sits directly downstream of the two per-VC TX FIFOs (VC0, VC1) in the PCIe transaction-layer TX path.
- Prefetches the head TLP entry of each FIFO into a per-VC stage.
- Checks the staged TLP against link-partner flow-control credits (header and data).
- Round-robin arbitrates between eligible VCs and presents one TLP per cycle on a valid/ready interface to the data-link layer.

Parameters:
- DATA_WIDTH, 224, width of one TLP entry; must match the FIFO entry width.
- HDR_CW, 8, header credit counter/limit width (PCIe field size).
- DATA_CW, 12, data credit counter/limit width (PCIe field size).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- vc0_empty  input  1  VC0 FIFO empty
- vc0_rd_en  output  1  VC0 FIFO pop; FIFO returns data on the next cycle and holds it until the next pop
- vc0_rd_data  input  DATA_WIDTH  VC0 FIFO read data
- vc1_empty, vc1_rd_en, vc1_rd_data: same as VC0, for VC1
- vc0_hdr_limit  input  HDR_CW  VC0 posted header credit limit (modular)
- vc0_data_limit  input  DATA_CW  VC0 data credit limit (modular)
- vc1_hdr_limit, vc1_data_limit: same as VC0, for VC1
- out_valid  output  1  TLP available to the link layer
- out_ready  input  1  link layer accepts
- out_data  output  DATA_WIDTH  TLP entry
- out_vc  output  1  VC of out_data

Behaviour:
- Entry format:
  - bit [DATA_WIDTH-1] has_data.
  - bits [DATA_WIDTH-2:DATA_WIDTH-11] length_dw; 0 encodes 1024.
- Credit requirement per TLP:
  - Header: 1.
  - Data: has_data ? ceil(len/4) : 0. Length 1024 requires 256; length 5 requires 2.
- Per-VC consumed counters hdr_cons (HDR_CW) and data_cons (DATA_CW), reset 0, wrap modulo 2^width.
- Eligibility: a staged TLP is eligible iff both checks pass:
  - ((hdr_limit - (hdr_cons+1)) mod 2^HDR_CW) <= 2^(HDR_CW-1)
  - ((data_limit - (data_cons+req)) mod 2^DATA_CW) <= 2^(DATA_CW-1)
- Limits are sampled combinationally each cycle. Limits rising later unblocks a stalled VC; no other action is required.
- Per-VC stage:
  - stage_valid flag, reset 0. Staged data is the FIFO's held rd_data; there is no copy register.
  - rd_en = !empty && (!stage_valid || grant_this_vc).
  - stage_valid <= rd_en ? 1 : (grant ? 0 : stage_valid).
- Output register:
  - free = !out_valid || out_ready.
  - At most one grant per cycle, and only when free.
- Arbitration:
  - If only one VC is eligible, grant it.
  - If both are eligible, grant the VC != last_grant.
  - last_grant resets to 1, so VC0 wins the first tie.
  - last_grant updates only on a grant.
- On grant:
  - out_data <= stage data; out_vc <= vc; out_valid <= 1.
  - Granted VC: hdr_cons += 1, data_cons += req, same edge.
- If free and no grant: out_valid <= 0.
- If out_valid && !out_ready: out_data, out_vc, out_valid hold stable. No grant, no counter update.
- Latency: the FIFO drives empty low in cycle C; rd_en is asserted in C; stage is valid in C+1; grant occurs in C+1; out_valid is 1 in C+2.
- Throughput: with out_ready=1 and credits available, 1 TLP/cycle sustained. A grant and the refill pop of the same VC happen in the same cycle.
- Blocking rules:
  - A credit-blocked VC stalls only itself.
  - The other VC continues to be granted.
  - There is no reordering within a VC.
- Reset (asynchronous, at any time):
  - out_valid=0, out_data=0, out_vc=0, rd_en=0.
  - Stages invalid, counters 0, last_grant=1.
  - A staged TLP is dropped; FIFO contents are the FIFOs' own concern.
- No pop is issued while empty=1, even if stage_valid=0.

Test Plan:
1. Single TLP, no data, into VC0 with limits hdr=8, data=0 -> out_valid 2 cycles after vc0_empty falls; out_vc=0; hdr_cons=1, data_cons=0.
2. Both VCs hold 4 TLPs, all limits ample, out_ready=1 -> output order VC0,VC1,VC0,VC1,... with no bubbles.
3. VC0 TLP with length=5 and data_limit=1 -> VC0 blocked while VC1 TLPs flow. Raise vc0_data_limit to 2 -> VC0 TLP issues next cycle; data_cons=2.
4. out_ready held 0 for 5 cycles with out_valid=1 -> out_data/out_vc stable, no rd_en, counters unchanged. Release -> transfer, and the next TLP appears the following cycle.
5. Wrap: vc1 hdr_cons=255, hdr_limit=0 -> TLP eligible, hdr_cons wraps to 0. Then with limit=0, the next TLP is blocked.
6. Assert rst_n low mid-stream with both stages valid and out_valid=1 -> all outputs 0 asynchronously. After release, the first tie is granted to VC0.
